// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: round-robin Wishbone-classic arbiter that merges NUM_PORTS
// core-side master ports onto the single Controller bus. Each transaction goes
// IDLE -> BUSY -> RESP, and the RESP cycle keeps a just-served port's
// lingering strobe from being seen as a new request.
// Optional feature: define CORE_BUS_TIMEOUT_EN to end stalled transactions with
// a port_err_o pulse after TIMEOUT_CYCLES BUSY cycles.
module core_bus_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            port_cyc_i,
  input  logic [NUM_PORTS-1:0]            port_stb_i,
  input  logic [NUM_PORTS-1:0]            port_we_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_data_i,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] port_data_o,
  output logic [NUM_PORTS-1:0]            port_ack_o,
  output logic [NUM_PORTS-1:0]            port_err_o,
  output logic                            wb_cyc_o,
  output logic                            wb_stb_o,
  output logic                            wb_we_o,
  output logic [ADDR_WIDTH-1:0]           wb_addr_o,
  output logic [DATA_WIDTH-1:0]           wb_data_o,
  input  logic [DATA_WIDTH-1:0]           wb_data_i,
  input  logic                            wb_ack_i
);

  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                        state_q, state_d;
  logic [GW-1:0]                 grant_q, last_grant_q, winner;
  logic [NUM_PORTS-1:0]          req, grant_oh, winner_oh;
  logic                          any_req, granted_cyc;
  logic                          we_q, resp_err_q;
  logic [ADDR_WIDTH-1:0]         addr_q;
  logic [DATA_WIDTH-1:0]         wdata_q;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rdata_q;
  logic                          timeout_hit;
  logic                          busy_ack, busy_abort, busy_timeout;

  assign req         = port_cyc_i & port_stb_i;
  assign any_req     = |req;
  assign grant_oh    = NUM_PORTS'(1) << grant_q;
  assign winner_oh   = NUM_PORTS'(1) << winner;
  assign granted_cyc = |(port_cyc_i & grant_oh);

  // Ack beats abort, abort beats timeout: a port that already left gets no error.
  assign busy_ack     = wb_ack_i;
  assign busy_abort   = !wb_ack_i && !granted_cyc;
  assign busy_timeout = !wb_ack_i && granted_cyc && timeout_hit;

  // Round-robin pick: first requester at or after last_grant+1, wrapping.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    winner = last_grant_q;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      if (req[(int'(last_grant_q) + i) % NUM_PORTS]) begin
        winner = GW'((int'(last_grant_q) + i) % NUM_PORTS);
      end
    end
  end

`ifdef CORE_BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q;

  assign timeout_hit = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Timeout counter: cleared on BUSY entry, counts every BUSY cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      tmo_cnt_q <= '0;
    end else if (state_q == BUSY) begin
      tmo_cnt_q <= tmo_cnt_q + TW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (any_req) state_d = BUSY;
      BUSY: begin
        if (busy_ack || busy_timeout) state_d = RESP;
        else if (busy_abort)          state_d = IDLE;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant bookkeeping, registered bus fields and per-port read data.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the read-data slices are ordinary output registers, not a memory,
    // so they are reset to give a defined all-zero output after reset.
    if (rst) begin
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_PORTS - 1);
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (any_req) begin
          grant_q      <= winner;
          last_grant_q <= winner;
          we_q         <= |(port_we_i & winner_oh);
          addr_q       <= port_addr_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_q      <= port_data_i[winner*DATA_WIDTH +: DATA_WIDTH];
        end
        BUSY: begin
          resp_err_q <= busy_timeout;
          if (busy_ack)          rdata_q[grant_q*DATA_WIDTH +: DATA_WIDTH] <= wb_data_i;
          else if (busy_timeout) rdata_q[grant_q*DATA_WIDTH +: DATA_WIDTH] <= '0;
        end
        default: ;
      endcase
    end
  end

  // Bus and response outputs decoded from the current state.
  always_comb begin
    wb_cyc_o   = (state_q == BUSY);
    wb_stb_o   = (state_q == BUSY);
    wb_we_o    = (state_q == BUSY) && we_q;
    port_ack_o = '0;
    port_err_o = '0;
    if (state_q == RESP) begin
      if (!resp_err_q) port_ack_o = grant_oh;
`ifdef CORE_BUS_TIMEOUT_EN
      else             port_err_o = grant_oh;
`endif
    end
  end

  assign wb_addr_o   = addr_q;
  assign wb_data_o   = wdata_q;
  assign port_data_o = rdata_q;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb_core_bus_arbiter: directed stimulus pushes expected responses into a
// scoreboard queue; an independent monitor pops and compares on every
// ack/err pulse. A small reactive slave answers after a programmable delay.
module tb_core_bus_arbiter;
  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     port_cyc_i, port_stb_i, port_we_i;
  logic [NP*AW-1:0]  port_addr_i;
  logic [NP*DW-1:0]  port_data_i;
  logic [NP*DW-1:0]  port_data_o;
  logic [NP-1:0]     port_ack_o, port_err_o;
  logic              wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0]     wb_addr_o;
  logic [DW-1:0]     wb_data_o;
  logic [DW-1:0]     wb_data_i;
  logic              wb_ack_i;

  core_bus_arbiter #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .port_cyc_i(port_cyc_i), .port_stb_i(port_stb_i), .port_we_i(port_we_i),
    .port_addr_i(port_addr_i), .port_data_i(port_data_i),
    .port_data_o(port_data_o), .port_ack_o(port_ack_o), .port_err_o(port_err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          slave_wait = -1;
  logic        use_fixed = 1'b0;
  logic [31:0] fixed_data = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic raise_req(input int p, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
    port_we_i[p]            = we;
    port_addr_i[p*AW +: AW] = addr;
    port_data_i[p*DW +: DW] = wdata;
    port_cyc_i[p]           = 1'b1;
    port_stb_i[p]           = 1'b1;
  endtask

  task automatic drop_req(input int p);
    port_cyc_i[p] = 1'b0;
    port_stb_i[p] = 1'b0;
    port_we_i[p]  = 1'b0;
  endtask

  // One complete transaction on port p; checks bus fields every BUSY cycle.
  task automatic run_txn(input int p, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int wait_k,
                         input logic exp_err, input logic [31:0] exp_data,
                         output int busy);
    exp_t e;
    bit   done;
    e.port = p; e.err = exp_err; e.data = exp_data;
    sb.push_back(e);
    slave_wait = wait_k;
    busy = 0;
    done = 1'b0;
    raise_req(p, we, addr, wdata);
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (wb_cyc_o) begin
        busy++;
        check("bus_addr", 64'(wb_addr_o), 64'(addr));
        check("bus_wdata", 64'(wb_data_o), 64'(wdata));
        check("bus_stb_we", 64'({wb_stb_o, wb_we_o}), 64'({1'b1, we}));
      end
      if (port_ack_o[p] || port_err_o[p]) done = 1'b1;
    end
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL txn_complete: port %0d got no ack/err, required one", p);
    end
    drop_req(p);
  endtask

  // Reactive slave: acks on the (slave_wait)-th BUSY cycle, never if negative.
  initial begin
    int cnt;
    cnt = 0;
    wb_ack_i  = 1'b0;
    wb_data_i = '0;
    forever begin
      @(negedge clk);
      if (wb_cyc_o && wb_stb_o) begin
        wb_ack_i  = (cnt == slave_wait);
        wb_data_i = use_fixed ? fixed_data : wb_addr_o + 32'h1000_0000;
        cnt++;
      end else begin
        cnt      = 0;
        wb_ack_i = 1'b0;
      end
    end
  end

  // Monitor: every response pulse is matched against the scoreboard head.
  initial begin
    exp_t e;
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (prev) check("pulse_width", 64'(port_ack_o | port_err_o), 64'(0));
      if (|(port_ack_o | port_err_o)) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 64'({port_ack_o, port_err_o}), 64'(0));
        end else begin
          e = sb.pop_front();
          check("resp_onehot", 64'($countones(port_ack_o | port_err_o)), 64'(1));
          check("resp_port", 64'(port_ack_o | port_err_o), 64'(1) << e.port);
          check("resp_is_err", 64'(port_err_o[e.port]), 64'(e.err));
          check("resp_data", 64'(port_data_o[e.port*DW +: DW]), 64'(e.data));
        end
        prev = 1'b1;
      end else begin
        prev = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1);
  end

  initial begin
    int   busy, held;
    int   ack_cyc[$];
    exp_t e;

    rst = 1'b1;
    port_cyc_i = '0; port_stb_i = '0; port_we_i = '0;
    port_addr_i = '0; port_data_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_bus_ctl", 64'({wb_cyc_o, wb_stb_o, wb_we_o}), 64'(0));
    check("rst_bus_addr", 64'(wb_addr_o), 64'(0));
    check("rst_bus_wdata", 64'(wb_data_o), 64'(0));
    check("rst_resp", 64'({port_ack_o, port_err_o}), 64'(0));
    check("rst_rdata", 64'(port_data_o), 64'(0));

    // Single read on port 0, zero-wait slave
    use_fixed = 1'b1;
    fixed_data = 32'hCAFE_F00D;
    run_txn(0, 1'b0, 32'h0000_0010, 32'h0, 0, 1'b0, 32'hCAFE_F00D, busy);
    check("t1_busy_cycles", 64'(busy), 64'(1));
    use_fixed = 1'b0;
    @(negedge clk);

    // Both ports requesting continuously from reset: 0,1,0,1 every 3 cycles
    rst = 1'b1;
    slave_wait = 0;
    raise_req(0, 1'b0, 32'h100, 32'h0);
    raise_req(1, 1'b0, 32'h200, 32'h0);
    for (int k = 0; k < 4; k++) begin
      e.port = k % 2;
      e.err  = 1'b0;
      e.data = (k % 2 == 0) ? 32'h1000_0100 : 32'h1000_0200;
      sb.push_back(e);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 60 && ack_cyc.size() < 4; c++) begin
      @(negedge clk);
      if (|port_ack_o) ack_cyc.push_back(c);
    end
    drop_req(0);
    drop_req(1);
    check("t2_ack_count", 64'(ack_cyc.size()), 64'(4));
    if (ack_cyc.size() == 4) begin
      for (int k = 1; k < 4; k++)
        check("t2_ack_spacing", 64'(ack_cyc[k] - ack_cyc[k-1]), 64'(3));
    end
    @(negedge clk);

    // Port 1 write with a 5-cycle slave stall: 6 stable BUSY cycles
    run_txn(1, 1'b1, 32'h80, 32'h1234_5678, 5, 1'b0, 32'h1000_0080, busy);
    check("t3_busy_cycles", 64'(busy), 64'(6));
    @(negedge clk);

`ifdef CORE_BUS_TIMEOUT_EN
    // Silent slave: error after 8 BUSY cycles, data slice cleared
    run_txn(0, 1'b0, 32'h40, 32'h0, -1, 1'b1, 32'h0, busy);
    check("t4_busy_cycles", 64'(busy), 64'(8));
    @(negedge clk);
`else
    // Silent slave with no timeout: bus held indefinitely, then port aborts
    slave_wait = -1;
    raise_req(0, 1'b0, 32'h40, 32'h0);
    held = 0;
    repeat (120) begin
      @(negedge clk);
      if (wb_cyc_o && !(|(port_ack_o | port_err_o))) held++;
    end
    check("t4_held_cycles", 64'(held), 64'(120));
    drop_req(0);
    @(negedge clk);
    check("t4_abort_release", 64'({wb_cyc_o, wb_stb_o}), 64'(0));
    @(negedge clk);
`endif

    // Ack on the same cycle the timeout would expire: ack wins
    run_txn(0, 1'b0, 32'h44, 32'h0, 7, 1'b0, 32'h1000_0044, busy);
    check("t5_busy_cycles", 64'(busy), 64'(8));
    @(negedge clk);

    // Reset during BUSY: bus released at once, no response
    slave_wait = -1;
    raise_req(1, 1'b0, 32'h300, 32'h0);
    repeat (3) @(negedge clk);
    check("t6a_busy_before_rst", 64'(wb_cyc_o), 64'(1));
    rst = 1'b1;
    #1;
    check("t6a_bus_on_rst", 64'({wb_cyc_o, wb_stb_o, wb_we_o}), 64'(0));
    check("t6a_resp_on_rst", 64'({port_ack_o, port_err_o}), 64'(0));
    @(negedge clk);
    drop_req(1);
    rst = 1'b0;
    @(negedge clk);
    check("t6a_idle_after_rst", 64'(wb_cyc_o), 64'(0));
    run_txn(0, 1'b0, 32'h500, 32'h0, 0, 1'b0, 32'h1000_0500, busy);
    @(negedge clk);

    // Granted port drops cyc during BUSY: abort, no response
    slave_wait = -1;
    raise_req(0, 1'b0, 32'h600, 32'h0);
    repeat (3) @(negedge clk);
    check("t6b_busy_before_abort", 64'(wb_cyc_o), 64'(1));
    port_cyc_i[0] = 1'b0;
    @(negedge clk);
    check("t6b_bus_after_abort", 64'({wb_cyc_o, wb_stb_o}), 64'(0));
    repeat (4) @(negedge clk);
    drop_req(0);
    run_txn(1, 1'b1, 32'h700, 32'hA5A5_0001, 1, 1'b0, 32'h1000_0700, busy);
    check("t6b_next_busy", 64'(busy), 64'(2));

    repeat (5) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/core_bus_arbiter.md
# core_bus_arbiter

Parametrised Wishbone-classic arbiter that multiplexes NUM_PORTS core-side master ports (e.g. instruction fetch, data access, debug) onto the single bus into the Controller. It replaces the tied-high `cyc`/`stb` wiring used so far with a real request/acknowledge handshake, fair round-robin grant and an optional bus-timeout error response. It sits between the core and the Controller `core_*` bus, in the `clk_core`/`rst_core` domain.

## Interface
- NUM_PORTS, 2: number of core-side master ports (1..8).
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width.
- TIMEOUT_CYCLES, 255: cycles in BUSY without `wb_ack_i` before error (only with BUS_TIMEOUT_EN).

Ports (per-port buses are flat, port p occupies slice [p*W +: W]):
- clk  in  1  core clock (single clock domain).
- rst  in  1  asynchronous, active-high reset.
- port_cyc_i  in  NUM_PORTS  per-port cycle valid.
- port_stb_i  in  NUM_PORTS  per-port strobe; a request is `cyc & stb`.
- port_we_i  in  NUM_PORTS  per-port write enable.
- port_addr_i  in  NUM_PORTS*ADDR_WIDTH  per-port address.
- port_data_i  in  NUM_PORTS*DATA_WIDTH  per-port write data.
- port_data_o  out  NUM_PORTS*DATA_WIDTH  per-port read data, valid with ack.
- port_ack_o  out  NUM_PORTS  one-cycle completion pulse.
- port_err_o  out  NUM_PORTS  one-cycle timeout error pulse.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  bus master controls to Controller.
- wb_addr_o  out  ADDR_WIDTH  bus address.
- wb_data_o  out  DATA_WIDTH  bus write data.
- wb_data_i  in  DATA_WIDTH  bus read data.
- wb_ack_i  in  1  bus acknowledge.

## Operation
- FSM states: IDLE, BUSY, RESP. Reset state IDLE.
- IDLE: if any port requests, pick winner by round-robin starting at `last_grant+1` (mod NUM_PORTS); register grant index, `we`, address, write data; set `last_grant`; go BUSY. No request: stay IDLE.
- BUSY: `wb_cyc_o = wb_stb_o = 1`, bus fields driven from registered copies (stable whole transaction).
  - `wb_ack_i = 1`: capture `wb_data_i` into granted port's `port_data_o` slice, drop `wb_cyc_o/wb_stb_o`, go RESP with ack flag.
  - Granted port drops `port_cyc_i`: abort — drop bus signals, go IDLE, no ack/err.
  - Timeout (see Configuration): drop bus, go RESP with err flag, read data slice cleared to 0.
- RESP: `port_ack_o[g]` (or `port_err_o[g]`) high for exactly this cycle; all requests ignored; go IDLE unconditionally. This blocks the still-high `stb` of the just-served port from being seen as a new request.
- `port_data_o` slices hold their last value until next completion on that port.
- Simultaneous `wb_ack_i` and timeout expiry: ack wins.
- `wb_ack_i` outside BUSY: ignored.
- NUM_PORTS = 1: pointer stays 0, behaviour otherwise identical.

## Timing
- Reset (async assert, sync release): all outputs 0, `last_grant = NUM_PORTS-1` (so port 0 wins first), timeout counter 0.
- Request seen at edge N (IDLE) -> `wb_cyc_o/stb_o` high after edge N.
- `wb_ack_i` sampled at edge M -> `port_ack_o` high after edge M for one cycle; `wb_cyc_o` low from same edge.
- Zero-wait-state bus: request to port ack = 2 cycles; back-to-back transactions from one port every 3 cycles.
- Timeout counter resets on BUSY entry, increments each BUSY cycle; error when count reaches TIMEOUT_CYCLES.
- Reset mid-transaction: bus released immediately, no ack/err emitted.

## Configuration
- `CORE_BUS_TIMEOUT_EN` defined: timeout counter (width `$clog2(TIMEOUT_CYCLES+1)`) compiled in; stalled transaction ends with `port_err_o` pulse after TIMEOUT_CYCLES BUSY cycles.
- Undefined: no counter; BUSY waits indefinitely for `wb_ack_i` or port abort; `port_err_o` tied to 0.

## Test plan
- Single read, port 0, addr 0x0000_0010, slave acks 1 cycle after stb with 0xCAFE_F00D -> `wb_addr_o = 0x10`, `port_ack_o = 2'b01` one cycle, `port_data_o[31:0] = 0xCAFE_F00D`.
- Both ports request continuously from reset -> grants alternate 0,1,0,1; each ack pulse on exactly one port, 3 cycles apart with zero-wait slave.
- Port 1 write 0x1234_5678 to 0x80, slave waits 5 cycles -> `wb_we_o=1`, addr/data stable all 6 BUSY cycles, `port_ack_o = 2'b10`.
- With `CORE_BUS_TIMEOUT_EN`, TIMEOUT_CYCLES=8, slave never acks -> `port_err_o[0]` pulses after 8 BUSY cycles, `wb_cyc_o` drops, data slice 0; without macro bus stays held 100+ cycles.
- Ack and timeout in same cycle -> ack pulse, no err.
- Assert `rst` during BUSY and, separately, drop `port_cyc_i` during BUSY -> bus outputs 0 immediately/next edge, no ack or err, next request served normally.
